// File: rtl/ext_code_seq.sv
// External-trigger code sequencer: loads a small code table and plays one
// entry per synchronised rising edge of an asynchronous trigger.
module ext_code_seq #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClr,
    input  logic             iSET_FLAG,
    input  logic [WIDTH-1:0] iSET_DATA,
    input  logic             iTrigger,
    input  logic             iRearm,
    input  logic             iLoop,
    input  logic             iGated,
    output logic [WIDTH-1:0] oCode,
    output logic [AW-1:0]    oIndex,
    output logic [AW:0]      oCount,
    output logic             oFull,
    output logic             oDone,
    output logic             oOvf
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             r_rise;
    logic             r_fall;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_code;
    logic [AW-1:0]    r_index;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_done;
    logic             r_ovf;

    logic             w_full;
    logic             w_wr;
    logic             w_play;
    logic             w_last;
    logic [AW:0]      w_rptr_nx;

    // Edge pulses are registered so a play lands three clocks after first sample.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= iTrigger;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
            r_fall  <= ~r_sync2 & r_prev;
        end
    end

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_wr      = iSET_FLAG & ~iClr & ~iRearm & ~w_full;
    assign w_play    = r_rise & (r_count != '0) & ~r_done;
    assign w_rptr_nx = {1'b0, r_rptr} + (AW+1)'(1);
    assign w_last    = (w_rptr_nx == r_count);

    always_ff @(posedge iClk) begin
        if (w_wr) begin
            r_mem[r_count[AW-1:0]] <= iSET_DATA;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_code  <= '0;
            r_index <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (iClr) begin
            r_code  <= '0;
            r_index <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (iRearm) begin
            r_code  <= '0;
            r_rptr  <= '0;
            r_done  <= 1'b0;
        end else begin
            if (iSET_FLAG) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + (AW+1)'(1);
                end
            end
            // Play reads the pre-write count, so a same-cycle write is not seen.
            if (w_play) begin
                r_code  <= r_mem[r_rptr];
                r_index <= r_rptr;
                if (w_last) begin
                    r_rptr <= '0;
                    r_done <= ~iLoop;
                end else begin
                    r_rptr <= w_rptr_nx[AW-1:0];
                end
            end else if (r_fall && iGated) begin
                r_code <= '0;
            end
        end
    end

    assign oCode  = r_code;
    assign oIndex = r_index;
    assign oCount = r_count;
    assign oFull  = w_full;
    assign oDone  = r_done;
    assign oOvf   = r_ovf;

endmodule

// File: tb/tb_ext_code_seq.sv
// Bench for ext_code_seq: table-driven playback vectors, scoreboard queue,
// and hand-written overflow, gating, empty-table and reset sequences.
module tb_ext_code_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr;
    logic        set_flag;
    logic [31:0] sdata;
    logic [7:0]  sdata8;
    logic        trig;
    logic        rearm;
    logic        loop;
    logic        gated;

    logic [31:0] code;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    logic        full, done, ovf;
    logic [7:0]  code8;
    logic [1:0]  idx8;
    logic [2:0]  cnt8;
    logic        full8, done8, ovf8;

    assign sdata8 = sdata[7:0];

    ext_code_seq #(.WIDTH(32), .DEPTH(8)) dut (
        .iClk(clk), .iRst_n(rst_n), .iClr(clr),
        .iSET_FLAG(set_flag), .iSET_DATA(sdata),
        .iTrigger(trig), .iRearm(rearm),
        .iLoop(loop), .iGated(gated),
        .oCode(code), .oIndex(idx), .oCount(cnt),
        .oFull(full), .oDone(done), .oOvf(ovf)
    );

    ext_code_seq #(.WIDTH(8), .DEPTH(4)) dut8 (
        .iClk(clk), .iRst_n(rst_n), .iClr(clr),
        .iSET_FLAG(set_flag), .iSET_DATA(sdata8),
        .iTrigger(trig), .iRearm(rearm),
        .iLoop(loop), .iGated(gated),
        .oCode(code8), .oIndex(idx8), .oCount(cnt8),
        .oFull(full8), .oDone(done8), .oOvf(ovf8)
    );

    typedef struct {
        logic [31:0] code;
        logic [2:0]  idx;
        logic        done;
    } exp_t;

    typedef struct {
        logic        rearm;
        logic        loop;
        logic [31:0] code;
        logic [2:0]  idx;
        logic        done;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[9];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk8   = 1'b0;
    logic [31:0] pre;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        set_flag = 1'b1;
        sdata    = d;
        tick();
        set_flag = 1'b0;
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // One trigger pulse; expected result queued at drive, checked at rise+3.
    task automatic pulse(input logic [31:0] prev, input logic [31:0] ecode,
                         input logic [2:0] eidx, input logic edone);
        exp_t e;
        e.code = ecode;
        e.idx  = eidx;
        e.done = edone;
        sb.push_back(e);
        trig = 1'b1;
        repeat (3) tick();
        chk("latency_hold", code, prev);
        tick();
        e = sb.pop_front();
        chk("code", code, e.code);
        chk("index", idx, e.idx);
        chk("done", done, e.done);
        if (chk8) begin
            chk("code8", code8, e.code[7:0]);
            chk("index8", idx8, e.idx[1:0]);
            chk("done8", done8, e.done);
        end
        tick();
        trig = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 32'h11, 3'd0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 32'h22, 3'd1, 1'b0};
        vt[2] = '{1'b0, 1'b0, 32'h33, 3'd2, 1'b1};
        vt[3] = '{1'b0, 1'b0, 32'h33, 3'd2, 1'b1};
        vt[4] = '{1'b1, 1'b1, 32'h11, 3'd0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 32'h22, 3'd1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 32'h33, 3'd2, 1'b0};
        vt[7] = '{1'b0, 1'b1, 32'h11, 3'd0, 1'b0};
        vt[8] = '{1'b0, 1'b1, 32'h22, 3'd1, 1'b0};

        rst_n = 1'b0; clr = 1'b0; set_flag = 1'b0; sdata = '0;
        trig = 1'b0; rearm = 1'b0; loop = 1'b0; gated = 1'b0;
        #12;
        chk("rst_code", code, 0);
        chk("rst_index", idx, 0);
        chk("rst_count", cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_code8", code8, 0);
        chk("rst_count8", cnt8, 0);
        rst_n = 1'b1;
        tick();

        chk8 = 1'b1;
        wr(32'h11); wr(32'h22); wr(32'h33);
        chk("load_count", cnt, 3);
        chk("load_count8", cnt8, 3);
        pre = '0;
        for (int i = 0; i < 9; i++) begin
            if (vt[i].rearm) begin
                do_rearm();
                chk("rearm_code", code, 0);
                chk("rearm_done", done, 0);
                chk("rearm_count", cnt, 3);
                pre = '0;
            end
            loop = vt[i].loop;
            pulse(pre, vt[i].code, vt[i].idx, vt[i].done);
            pre = vt[i].code;
        end
        chk8 = 1'b0;

        do_clr();
        loop = 1'b0;
        for (int i = 0; i < 9; i++) wr(32'hA0 + i);
        chk("ovf_count", cnt, 8);
        chk("ovf_full", full, 1);
        chk("ovf_flag", ovf, 1);
        do_rearm();
        pre = '0;
        for (int i = 0; i < 8; i++) begin
            pulse(pre, 32'hA0 + i, 3'(i), i == 7);
            pre = 32'hA0 + i;
        end
        pulse(32'hA7, 32'hA7, 3'd7, 1'b1);
        do_clr();
        chk("clr_count", cnt, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_code", code, 0);
        chk("clr_full", full, 0);
        chk("clr_done", done, 0);

        wr(32'h55); wr(32'h66);
        gated = 1'b0;
        pulse(32'h0, 32'h55, 3'd0, 1'b0);
        gated = 1'b1;
        trig  = 1'b1;
        repeat (3) tick();
        chk("gate_pre", code, 32'h55);
        tick();
        chk("gate_code", code, 32'h66);
        chk("gate_index", idx, 1);
        repeat (6) tick();
        chk("gate_held_high", code, 32'h66);
        trig = 1'b0;
        repeat (3) tick();
        chk("gate_fall_pre", code, 32'h66);
        tick();
        chk("gate_fall_code", code, 0);
        chk("gate_fall_index", idx, 1);
        chk("gate_done", done, 1);
        repeat (3) tick();
        gated = 1'b0;

        do_clr();
        trig = 1'b1;
        repeat (4) tick();
        chk("empty_code", code, 0);
        chk("empty_count", cnt, 0);
        trig = 1'b0;
        repeat (5) tick();
        trig = 1'b1;
        repeat (3) tick();
        set_flag = 1'b1;
        sdata    = 32'h77;
        tick();
        set_flag = 1'b0;
        chk("same_cyc_code", code, 0);
        chk("same_cyc_count", cnt, 1);
        chk("same_cyc_done", done, 0);
        repeat (2) tick();
        trig = 1'b0;
        repeat (5) tick();
        pulse(32'h0, 32'h77, 3'd0, 1'b1);

        do_clr();
        wr(32'h11); wr(32'h22); wr(32'h33);
        pulse(32'h0, 32'h11, 3'd0, 1'b0);
        pulse(32'h11, 32'h22, 3'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code", code, 0);
        chk("mid_rst_index", idx, 0);
        chk("mid_rst_count", cnt, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_code8", code8, 0);
        chk("mid_rst_count8", cnt8, 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_count", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
